// File: rtl/pkt_capture_pkg.sv
// Shared types and constants for the packet capture front end.
package pkt_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DROP,
    ISSUE,
    WAIT
  } state_t;

  localparam int CTRL_VALID_BIT = 31;
  localparam int CTRL_TRUNC_BIT = 16;
  localparam int CTRL_LEN_MSB   = 15;
  localparam int WORD_BYTES     = 4;

  function automatic logic [31:0] make_control(input logic valid,
                                               input logic trunc,
                                               input logic [CTRL_LEN_MSB:0] len);
    logic [31:0] c;
    c                 = '0;
    c[CTRL_VALID_BIT] = valid;
    c[CTRL_TRUNC_BIT] = trunc;
    c[CTRL_LEN_MSB:0] = len;
    return c;
  endfunction

endpackage

// File: rtl/pkt_ring_alloc.sv
// Ring buffer write pointer: wraps to the base at allocation when a
// maximum-size frame would not fit, advances to the frame end on completion.
module pkt_ring_alloc #(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_BYTES     = 32'h0010_0000,
  parameter int          MAX_PKT_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_alloc,
  input  logic        i_advance,
  input  logic [31:0] i_next_ptr,
  output logic [31:0] o_alloc_addr
);

  logic [31:0] r_wr_ptr;
  logic [32:0] w_need;
  logic [32:0] w_limit;
  logic        w_wrap;

  // 33-bit compare so a pointer near 2^32 cannot overflow into a false fit
  assign w_need       = {1'b0, r_wr_ptr} + 33'(MAX_PKT_BYTES);
  assign w_limit      = {1'b0, BUF_BASE} + {1'b0, BUF_BYTES};
  assign w_wrap       = w_need > w_limit;
  assign o_alloc_addr = w_wrap ? BUF_BASE : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= BUF_BASE;
    end else if (i_alloc) begin
      r_wr_ptr <= o_alloc_addr;
    end else if (i_advance) begin
      r_wr_ptr <= i_next_ptr;
    end
  end

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Frame capture front end: stream sink -> packet FIFO plus one DDR descriptor
// per frame. Define CAPTURE_STATS_EN to add saturating frame statistics.
module pkt_capture_ctrl
  import pkt_capture_pkg::*;
#(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_BYTES     = 32'h0010_0000,
  parameter int          MAX_PKT_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_empty,
  output logic        in_ready,
  output logic        fifo_wr,
  output logic [31:0] fifo_in,
  input  logic        fifo_full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] control
`ifdef CAPTURE_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_trunc
`endif
);

  localparam logic [15:0] MAX_WORDS = 16'(MAX_PKT_BYTES / WORD_BYTES);

  state_t      r_state;
  logic [31:0] r_begin;
  logic [15:0] r_words;
  logic [15:0] r_bytes;
  logic        r_trunc;
  logic        r_fifo_wr;
  logic [31:0] r_fifo_in;
  logic        r_wr_ctrl;
  logic [31:0] r_pkt_begin;
  logic [31:0] r_pkt_end;
  logic [31:0] r_control;

  logic        w_ready;
  logic        w_accept;
  logic        w_sop_cap;
  logic        w_drop_start;
  logic        w_release;
  logic [15:0] w_beat_bytes;
  logic [31:0] w_pkt_end;
  logic [31:0] w_alloc_addr;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE, DROP: w_ready = 1'b1;
      CAPTURE:    w_ready = !fifo_full;
      default:    w_ready = 1'b0;
    endcase
  end

  // Held low while reset is asserted so upstream never sees a ready in reset
  assign in_ready     = reset && w_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_sop_cap    = (r_state == IDLE) && w_accept && in_sop && capture_en;
  assign w_drop_start = (r_state == IDLE) && w_accept && in_sop && !capture_en;
  assign w_release    = (r_state == WAIT) && wr_ctrl_rdy;
  assign w_beat_bytes = in_eop ? (16'(WORD_BYTES) - {14'd0, in_empty}) : 16'(WORD_BYTES);
  assign w_pkt_end    = r_begin + {14'd0, r_words, 2'b00};

  pkt_ring_alloc #(
    .BUF_BASE      (BUF_BASE),
    .BUF_BYTES     (BUF_BYTES),
    .MAX_PKT_BYTES (MAX_PKT_BYTES)
  ) u_ring_alloc (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (w_sop_cap),
    .i_advance    (w_release),
    .i_next_ptr   (r_pkt_end),
    .o_alloc_addr (w_alloc_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_begin     <= BUF_BASE;
      r_words     <= '0;
      r_bytes     <= '0;
      r_trunc     <= 1'b0;
      r_fifo_wr   <= 1'b0;
      r_fifo_in   <= '0;
      r_wr_ctrl   <= 1'b0;
      r_pkt_begin <= BUF_BASE;
      r_pkt_end   <= BUF_BASE;
      r_control   <= '0;
    end else begin
      r_fifo_wr <= 1'b0;
      r_wr_ctrl <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sop_cap) begin
            r_begin   <= w_alloc_addr;
            r_words   <= 16'd1;
            r_bytes   <= w_beat_bytes;
            r_trunc   <= 1'b0;
            r_fifo_wr <= 1'b1;
            r_fifo_in <= in_data;
            r_state   <= in_eop ? ISSUE : CAPTURE;
          end else if (w_drop_start) begin
            // A single-beat dropped frame is already over
            r_state <= in_eop ? IDLE : DROP;
          end
        end
        CAPTURE: begin
          if (w_accept) begin
            if (r_words < MAX_WORDS) begin
              r_fifo_wr <= 1'b1;
              r_fifo_in <= in_data;
              r_words   <= r_words + 16'd1;
              r_bytes   <= r_bytes + w_beat_bytes;
            end else begin
              r_trunc <= 1'b1;
            end
            if (in_eop) begin
              r_state <= ISSUE;
            end
          end
        end
        DROP: begin
          if (w_accept && in_eop) begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_pkt_begin <= r_begin;
          r_pkt_end   <= w_pkt_end;
          r_control   <= make_control(1'b1, r_trunc, r_bytes);
          r_wr_ctrl   <= 1'b1;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (wr_ctrl_rdy) begin
            r_control[CTRL_VALID_BIT] <= 1'b0;
            r_state                   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_wr   = r_fifo_wr;
  assign fifo_in   = r_fifo_in;
  assign wr_ctrl   = r_wr_ctrl;
  assign pkt_begin = r_pkt_begin;
  assign pkt_end   = r_pkt_end;
  assign control   = r_control;

`ifdef CAPTURE_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_drops;
  logic [31:0] r_stat_trunc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_pkts  <= '0;
      r_stat_drops <= '0;
      r_stat_trunc <= '0;
    end else begin
      if ((r_state == ISSUE) && (r_stat_pkts != '1)) begin
        r_stat_pkts <= r_stat_pkts + 32'd1;
      end
      if ((r_state == ISSUE) && r_trunc && (r_stat_trunc != '1)) begin
        r_stat_trunc <= r_stat_trunc + 32'd1;
      end
      if (w_drop_start && (r_stat_drops != '1)) begin
        r_stat_drops <= r_stat_drops + 32'd1;
      end
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_drops = r_stat_drops;
  assign stat_trunc = r_stat_trunc;
`endif

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Scoreboard bench for pkt_capture_ctrl (4 KiB ring, 256-byte frame limit).
module tb_pkt_capture_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BYTES = 32'h0000_1000;
  localparam int          MAXB  = 256;
  localparam int          MAXW  = MAXB / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        in_ready;
  logic        fifo_wr;
  logic [31:0] fifo_in;
  logic        fifo_full = 1'b0;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy = 1'b0;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] control;
`ifdef CAPTURE_STATS_EN
  logic [31:0] stat_pkts;
  logic [31:0] stat_drops;
  logic [31:0] stat_trunc;
`endif

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_ctrl = 0;
  logic [31:0] exp_data_q[$];
  logic [95:0] exp_desc_q[$];
  logic [31:0] mon_data;
  logic [95:0] mon_desc;
  logic [31:0] m_ptr = BASE;
  logic [31:0] last_end = BASE;

  always #5 clk = ~clk;

  pkt_capture_ctrl #(
    .BUF_BASE      (BASE),
    .BUF_BYTES     (BYTES),
    .MAX_PKT_BYTES (MAXB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .in_ready    (in_ready),
    .fifo_wr     (fifo_wr),
    .fifo_in     (fifo_in),
    .fifo_full   (fifo_full),
    .wr_ctrl     (wr_ctrl),
    .wr_ctrl_rdy (wr_ctrl_rdy),
    .pkt_begin   (pkt_begin),
    .pkt_end     (pkt_end),
    .control     (control)
`ifdef CAPTURE_STATS_EN
    ,
    .stat_pkts   (stat_pkts),
    .stat_drops  (stat_drops),
    .stat_trunc  (stat_trunc)
`endif
  );

  // Output monitor: FIFO writes and descriptors are popped from the scoreboard
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      n_wr++;
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_unexpected: fifo_in=%h written, required no write", fifo_in);
      end else begin
        mon_data = exp_data_q.pop_front();
        if (fifo_in !== mon_data) begin
          errors++;
          $display("FAIL fifo_data: got %h, required %h", fifo_in, mon_data);
        end
      end
    end
    if (wr_ctrl === 1'b1) begin
      n_ctrl++;
      checks++;
      $display("desc: begin=%h end=%h control=%h", pkt_begin, pkt_end, control);
      if (exp_desc_q.size() == 0) begin
        errors++;
        $display("FAIL desc_unexpected: wr_ctrl pulse, required none");
      end else begin
        mon_desc = exp_desc_q.pop_front();
        if ({pkt_begin, pkt_end, control} !== mon_desc) begin
          errors++;
          $display("FAIL desc: got %h/%h/%h, required %h/%h/%h", pkt_begin, pkt_end, control,
                   mon_desc[95:64], mon_desc[63:32], mon_desc[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; wr_ctrl_rdy = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    m_ptr = BASE;
    exp_data_q.delete();
    exp_desc_q.delete();
  endtask

  task automatic send_frame(input int nbytes, input bit cap, input int stall_beat);
    int nbeats, empty, words, bytes, stall_left, guard;
    bit trunc, acc, exp_rdy;
    logic [32:0] need;
    logic [31:0] begin_a, d;
    nbeats  = (nbytes + 3) / 4;
    empty   = nbeats * 4 - nbytes;
    need    = {1'b0, m_ptr} + 33'(MAXB);
    begin_a = (need > ({1'b0, BASE} + {1'b0, BYTES})) ? BASE : m_ptr;
    words = 0; bytes = 0; trunc = 1'b0;
    @(posedge clk); #1;
    capture_en = cap;
    for (int i = 0; i < nbeats; i++) begin
      d        = $urandom;
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == nbeats - 1);
      in_empty = (i == nbeats - 1) ? 2'(empty) : 2'd0;
      in_data  = d;
      stall_left = (i == stall_beat) ? 3 : 0;
      guard = 0;
      acc = 1'b0;
      while (!acc) begin
        fifo_full = (stall_left > 0);
        @(negedge clk);
        exp_rdy = (i == 0 || !cap) ? 1'b1 : !fifo_full;
        checks++;
        if (in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL in_ready beat %0d: got %b, required %b", i, in_ready, exp_rdy);
        end
        acc = (in_ready === 1'b1);
        if (acc && cap) begin
          if (words < MAXW) begin
            exp_data_q.push_back(d);
            words++;
            bytes += (i == nbeats - 1) ? (4 - empty) : 4;
          end else begin
            trunc = 1'b1;
          end
        end
        @(posedge clk); #1;
        if (!acc) begin
          stall_left--;
          guard++;
          if (guard > 20) begin
            errors++;
            $display("FAIL accept_timeout beat %0d: not accepted in 20 cycles, required acceptance", i);
            acc = 1'b1;
          end
        end
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0; fifo_full = 1'b0;
    if (cap) begin
      last_end = begin_a + 32'(4 * words);
      exp_desc_q.push_back({begin_a, last_end,
                            32'h8000_0000 | (32'(trunc) << 16) | 32'(bytes)});
    end
  endtask

  task automatic wait_desc();
    int guard;
    guard = 0;
    while (exp_desc_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_desc_q.size() != 0) begin
      errors++;
      $display("FAIL desc_timeout: %0d descriptors outstanding, required 0", exp_desc_q.size());
      exp_desc_q.delete();
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready: got %b, required 0", in_ready);
    end
  endtask

  task automatic give_rdy();
    @(posedge clk); #1; wr_ctrl_rdy = 1'b1;
    @(posedge clk); #1; wr_ctrl_rdy = 1'b0;
    m_ptr = last_end;
    @(negedge clk);
    checks++;
    if (control[31] !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: control[31]=%b in_ready=%b, required 0 and 1", control[31], in_ready);
    end
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL fifo_missing: %0d words unwritten, required 0", exp_data_q.size());
      exp_data_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, fifo_wr, wr_ctrl} !== 3'b000 || pkt_begin !== BASE || pkt_end !== BASE || control !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: rdy/wr/ctrl=%b%b%b begin=%h end=%h control=%h, required 000 %h %h 0",
               in_ready, fifo_wr, wr_ctrl, pkt_begin, pkt_end, control, BASE, BASE);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_drop();
    int w0, c0;
    w0 = n_wr; c0 = n_ctrl;
    send_frame(20, 1'b0, -1);
    repeat (5) @(negedge clk);
    checks++;
    if (n_wr != w0 || n_ctrl != c0) begin
      errors++;
      $display("FAIL drop: writes=%0d pulses=%0d, required 0 and 0", n_wr - w0, n_ctrl - c0);
    end
`ifdef CAPTURE_STATS_EN
    checks++;
    if (stat_drops !== 32'd1) begin
      errors++;
      $display("FAIL stat_drops: got %0d, required 1", stat_drops);
    end
`endif
  endtask

  task automatic test_basic();
    int w0, c0;
    w0 = n_wr; c0 = n_ctrl;
    send_frame(10, 1'b1, -1);
    wait_desc();
    checks++;
    if (pkt_begin !== 32'h0 || pkt_end !== 32'hC || control !== 32'h8000_000A) begin
      errors++;
      $display("FAIL basic_desc: got %h/%h/%h, required 0/c/8000000a", pkt_begin, pkt_end, control);
    end
    checks++;
    if (n_wr - w0 != 3 || n_ctrl - c0 != 1) begin
      errors++;
      $display("FAIL basic_counts: writes=%0d pulses=%0d, required 3 and 1", n_wr - w0, n_ctrl - c0);
    end
    give_rdy();
    send_frame(8, 1'b1, -1);
    wait_desc();
    checks++;
    if (pkt_begin !== 32'hC) begin
      errors++;
      $display("FAIL next_begin: got %h, required c", pkt_begin);
    end
    give_rdy();
  endtask

  task automatic test_truncate();
    int w0;
    w0 = n_wr;
    send_frame(300, 1'b1, -1);
    wait_desc();
    checks++;
    if (control !== 32'h8001_0100 || (pkt_end - pkt_begin) !== 32'h100 || n_wr - w0 != 64) begin
      errors++;
      $display("FAIL truncate: control=%h span=%h writes=%0d, required 80010100 100 64",
               control, pkt_end - pkt_begin, n_wr - w0);
    end
    give_rdy();
  endtask

  task automatic test_stall();
    int w0;
    w0 = n_wr;
    send_frame(40, 1'b1, 4);
    wait_desc();
    checks++;
    if (n_wr - w0 != 10 || (pkt_end - pkt_begin) !== 32'd40 || control[15:0] !== 16'd40) begin
      errors++;
      $display("FAIL stall: writes=%0d span=%0d len=%0d, required 10 40 40",
               n_wr - w0, pkt_end - pkt_begin, control[15:0]);
    end
    give_rdy();
  endtask

  task automatic test_back_to_back();
    send_frame(16, 1'b1, -1);
    wait_desc();
    @(posedge clk); #1;
    capture_en = 1'b1; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = $urandom;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_wait_ready: got %b, required 0", in_ready);
      end
    end
    @(posedge clk); #1; wr_ctrl_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rdy_cycle: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk); #1; wr_ctrl_rdy = 1'b0;
    m_ptr = last_end;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_rdy: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b0; in_sop = 1'b0;
    send_frame(24, 1'b1, -1);
    wait_desc();
    give_rdy();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    capture_en = 1'b1; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_empty = 2'd0;
    in_data = $urandom; exp_data_q.push_back(in_data);
    @(posedge clk); #1;
    in_sop = 1'b0; in_data = $urandom; exp_data_q.push_back(in_data);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_ready, fifo_wr, wr_ctrl} !== 3'b000 || pkt_begin !== BASE || pkt_end !== BASE || control !== 32'h0) begin
      errors++;
      $display("FAIL midreset_values: rdy/wr/ctrl=%b%b%b begin=%h end=%h control=%h, required 000 %h %h 0",
               in_ready, fifo_wr, wr_ctrl, pkt_begin, pkt_end, control, BASE, BASE);
    end
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_fifo: %0d words unwritten, required 0", exp_data_q.size());
      exp_data_q.delete();
    end
    #1 reset = 1'b1;
    m_ptr = BASE;
    send_frame(12, 1'b1, -1);
    wait_desc();
    checks++;
    if (pkt_begin !== BASE) begin
      errors++;
      $display("FAIL midreset_ptr: begin=%h, required %h", pkt_begin, BASE);
    end
    give_rdy();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      send_frame(256, 1'b1, -1);
      wait_desc();
      give_rdy();
    end
    send_frame(128, 1'b1, -1);
    wait_desc();
    checks++;
    if (pkt_begin !== 32'hF00) begin
      errors++;
      $display("FAIL exact_fit: begin=%h, required f00", pkt_begin);
    end
    give_rdy();
    send_frame(64, 1'b1, -1);
    wait_desc();
    checks++;
    if (pkt_begin !== 32'h0 || pkt_end !== 32'h40) begin
      errors++;
      $display("FAIL wrap: begin=%h end=%h, required 0 40", pkt_begin, pkt_end);
    end
    give_rdy();
  endtask

  initial begin
    test_reset();
    test_drop();
    test_basic();
    test_truncate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
